imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Accepts a byte stream from the host link (UART receiver or testbench) over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one-cycle word writes to the IMEM storage at word-index addresses 0..IMEM_SIZE-1. These are the same word indices the fetch side uses to read.
- Runs before the core is released from program-load; reports completion, word count and truncation.

Parameters:
- IMEM_LEN, 32: instruction word width in bits. Fixed at 32; 4 bytes per word.
- IMEM_SIZE, 10: maximum number of instruction words.
- CNT_W, 4: width of word_count; must be at least clog2(IMEM_SIZE+1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load. Honoured in IDLE and DONE only.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_last  in  1  qualifies the final byte of the program; sampled with byte_valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle write strobe to IMEM.
- imem_waddr  out  64  word index being written.
- imem_wdata  out  IMEM_LEN  instruction word being written.
- busy  out  1  high while in LOAD.
- done  out  1  load complete; held until start or reset.
- overflow  out  1  memory filled without byte_last; stream was truncated.
- word_count  out  CNT_W  number of words written in the current load.

Behaviour:
- Reset:
  - Asynchronous and immediate: state=IDLE.
  - All outputs 0: byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, word_count.
  - Internal byte_idx and assembly register cleared.
  - Reset mid-load aborts with no further write. Words already written are not erased.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a registered state decode (high only in LOAD), never combinational from byte_valid. Gaps in byte_valid stall assembly indefinitely.
- States:
  - IDLE: byte_ready=0. start -> LOAD; clear byte_idx, word_count, done, overflow.
  - LOAD: byte_ready=1, busy=1. Accepted byte goes to assembly bits [8*byte_idx+7 : 8*byte_idx]; byte_idx increments mod 4.
  - Word write is triggered by either:
    - the accepted byte having byte_idx==3, or
    - the accepted byte carrying byte_last.
  - On a word write, at that edge the loader registers:
    - imem_we=1;
    - imem_waddr = word_count, zero-extended to 64 bits;
    - imem_wdata = the assembled word, with bytes above the last accepted byte forced to 0;
    - word_count += 1.
  - imem_we is high for exactly the following cycle. Latency: 1 cycle from the completing byte handshake to the write strobe.
  - Leaving LOAD, decided at the edge of the triggering byte:
    - byte_last -> DONE, overflow=0.
    - Otherwise, if the new word_count == IMEM_SIZE -> DONE, overflow=1.
    - Otherwise stay in LOAD; byte_idx and the assembly register clear after each write.
  - start while in LOAD is ignored.
  - DONE: byte_ready=0, done=1. done and the final imem_we pulse are high in the same cycle. start -> LOAD with counters, done and overflow cleared; the next load writes from address 0.
- No write ever occurs at an address >= IMEM_SIZE.
- imem_waddr and imem_wdata hold their last value when imem_we=0.
- In IDLE, start and byte_valid in the same cycle: the byte is not accepted (byte_ready=0).

Test Plan:
- Reset: assert reset with random inputs.
  -> All outputs 0 within the same cycle; byte_ready stays 0 until a start pulse.
- Two-word load: start; bytes 0F 00 00 00, then 40 00 00 00 with byte_last on the final byte.
  -> imem_we pulses with waddr 0 / wdata 0x0000000F and waddr 1 / wdata 0x00000040.
  -> done=1 on the second pulse; word_count=2; overflow=0; byte_ready=0 afterwards.
- Partial word: start; bytes 59, 01 with byte_last on 01.
  -> Single write waddr 0, wdata 0x00000159; done=1; word_count=1.
- Fill/truncate: start; 44 bytes with no byte_last.
  -> Exactly 10 writes, waddr 0..9, wdata matching the packed bytes.
  -> done=1 and overflow=1 after the 40th byte; bytes 41-44 never accepted.
- Backpressure and abort: start; 6 bytes with byte_valid toggling every other cycle, then reset asserted mid-cycle.
  -> Exactly one write (waddr 0), then all outputs 0 immediately.
  -> A new start followed by 4 bytes writes waddr 0 again.
- Restart and ignored start: pulse start in LOAD after 2 bytes, then complete the load; then pulse start in DONE.
  -> The first start has no effect on assembly or address.
  -> The second start clears done, overflow and word_count, and the next write uses waddr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit IMEM word writes; write strobe 1 cycle after the completing byte.
// byte_ready is a pure state decode (high only in LOAD); byte_valid gaps simply stall assembly.
module imem_loader #(
    parameter int IMEM_LEN  = 32,
    parameter int IMEM_SIZE = 10,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                byte_ready,
    output logic                imem_we,
    output logic [63:0]         imem_waddr,
    output logic [IMEM_LEN-1:0] imem_wdata,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          byte_idx;
    logic [IMEM_LEN-1:0] asm_word;
    logic [IMEM_LEN-1:0] word_nxt;
    logic                accept;
    logic                wr_trig;
    logic                fill;
    logic                load_start;

    assign byte_ready = (state == LOAD);
    assign busy       = (state == LOAD);
    assign done       = (state == DONE);

    assign accept     = byte_valid && byte_ready;
    assign wr_trig    = accept && ((byte_idx == 2'd3) || byte_last);
    assign fill       = wr_trig && !byte_last &&
                        ((word_count + CNT_W'(1)) == CNT_W'(IMEM_SIZE));
    assign load_start = start && ((state == IDLE) || (state == DONE));

    // Bytes above the incoming one are already zero: the assembly register clears after every write.
    always_comb begin
        word_nxt = asm_word;
        word_nxt[8*byte_idx +: 8] = byte_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (wr_trig && (byte_last || fill)) state_nxt = DONE;
            DONE: if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            asm_word   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= wr_trig;
            if (load_start) begin
                byte_idx   <= 2'd0;
                asm_word   <= '0;
                overflow   <= 1'b0;
                word_count <= '0;
            end else if (accept) begin
                if (wr_trig) begin
                    imem_waddr <= {{(64-CNT_W){1'b0}}, word_count};
                    imem_wdata <= word_nxt;
                    word_count <= word_count + CNT_W'(1);
                    overflow   <= fill;
                    byte_idx   <= 2'd0;
                    asm_word   <= '0;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                    asm_word <= word_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and popped on each imem_we.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  word_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_addr[$];
    logic [31:0] exp_data[$];

    imem_loader #(.IMEM_LEN(32), .IMEM_SIZE(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && imem_we === 1'b1) begin
            n_tests++;
            if (exp_data.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", imem_waddr, imem_wdata);
            end else begin
                logic [63:0] ea;
                logic [31:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (imem_waddr !== ea || imem_wdata !== ed) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             imem_waddr, imem_wdata, ea, ed);
                end
            end
        end
    end

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_addr.push_back(64'(addr));
        exp_data.push_back(data);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Holds a byte until accepted (returns at edge+1); a refused byte after the budget is a failure.
    task automatic send_byte(input logic [7:0] b, input logic last);
        bit rdy;
        bit acc;
        int t;
        acc = 0;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        while (!acc && t < 20) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk); #1;
            t++;
            acc = rdy;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL byte_timeout: byte %02h got not accepted, required accepted", b);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_data.size());
            exp_addr.delete();
            exp_data.delete();
        end
    endtask

    task automatic test_reset();
        start      = 1'($urandom);
        byte_valid = 1'($urandom);
        byte_data  = 8'($urandom);
        byte_last  = 1'($urandom);
        reset      = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, word_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
                     byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, word_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start      = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            byte_last  = 1'($urandom);
        end
        start = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (byte_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_ready: got rdy=%b busy=%b, required 0 0", byte_ready, busy);
            end
        end
        byte_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_word();
        pulse_start();
        push_exp(0, 32'h0000000F);
        push_exp(1, 32'h00000040);
        send_byte(8'h0F, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 1);
        n_tests++;
        if (imem_we !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL two_word_done_with_we: got we=%b done=%b, required 1 1", imem_we, done);
        end
        check_drained("two_word");
        n_tests++;
        if (done !== 1'b1 || word_count !== 4'd2 || overflow !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL two_word_status: got done=%b cnt=%0d ovf=%b rdy=%b, required 1 2 0 0",
                     done, word_count, overflow, byte_ready);
        end
    endtask

    task automatic test_partial();
        pulse_start();
        push_exp(0, 32'h00000159);
        send_byte(8'h59, 0);
        send_byte(8'h01, 1);
        check_drained("partial");
        n_tests++;
        if (done !== 1'b1 || word_count !== 4'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_status: got done=%b cnt=%0d ovf=%b, required 1 1 0", done, word_count, overflow);
        end
    endtask

    task automatic test_fill();
        logic [7:0] b[44];
        for (int k = 0; k < 44; k++) b[k] = 8'(k * 13 + 5);
        pulse_start();
        for (int w = 0; w < 10; w++)
            push_exp(w, {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
        for (int k = 0; k < 40; k++) send_byte(b[k], 0);
        n_tests++;
        if (done !== 1'b1 || overflow !== 1'b1 || word_count !== 4'd10) begin
            n_fail++;
            $display("FAIL fill_status: got done=%b ovf=%b cnt=%0d, required 1 1 10", done, overflow, word_count);
        end
        byte_valid = 1'b1;
        for (int k = 40; k < 44; k++) begin
            byte_data = b[k];
            @(negedge clk);
            n_tests++;
            if (byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_extra_byte: got rdy=%b for byte %0d, required 0", byte_ready, k + 1);
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check_drained("fill");
    endtask

    task automatic test_backpressure_abort();
        logic [7:0] b[6];
        for (int k = 0; k < 6; k++) b[k] = 8'(8'hA0 + k);
        pulse_start();
        push_exp(0, {b[3], b[2], b[1], b[0]});
        for (int k = 0; k < 6; k++) begin
            send_byte(b[k], 0);
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, word_count} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
                     byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, word_count);
        end
        n_tests++;
        if (exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL abort_write_count: got %0d pending, required 0", exp_data.size());
            exp_addr.delete();
            exp_data.delete();
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        push_exp(0, 32'h44332211);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
        check_drained("abort_reload");
    endtask

    task automatic test_restart();
        pulse_start();
        n_tests++;
        if (done !== 1'b0 || overflow !== 1'b0 || word_count !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b ovf=%b cnt=%0d busy=%b, required 0 0 0 1",
                     done, overflow, word_count, busy);
        end
        push_exp(0, 32'hDEADBEEF);
        push_exp(1, 32'h00003412);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0);
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || word_count !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_ignored_start: got busy=%b cnt=%0d, required 1 0", busy, word_count);
        end
        send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 1);
        check_drained("restart_first");
        n_tests++;
        if (done !== 1'b1 || word_count !== 4'd2) begin
            n_fail++;
            $display("FAIL restart_first_status: got done=%b cnt=%0d, required 1 2", done, word_count);
        end
        pulse_start();
        n_tests++;
        if (done !== 1'b0 || overflow !== 1'b0 || word_count !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_done_start: got done=%b ovf=%b cnt=%0d, required 0 0 0", done, overflow, word_count);
        end
        push_exp(0, 32'h87654321);
        send_byte(8'h21, 0); send_byte(8'h43, 0); send_byte(8'h65, 0); send_byte(8'h87, 1);
        check_drained("restart_second");
        n_tests++;
        if (done !== 1'b1 || word_count !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_second_status: got done=%b cnt=%0d, required 1 1", done, word_count);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        test_reset();
        test_two_word();
        test_partial();
        test_fill();
        test_restart();
        test_backpressure_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
